// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin share of one RAM port between requesters A and B (valid/ready/write/addr/idata in, rvalid/rdata out) with read data steered back after LATENCY cycles
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_write,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_idata,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_idata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_enable,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_idata,
  input  logic [DATA_WIDTH-1:0] ram_odata
);
  logic               last_q, last_d;
  logic               gnt_a, gnt_b;
  logic [LATENCY-1:0] vld_q, vld_d, own_q, own_d;
  always_comb begin
    gnt_a      = !reset && a_valid && (!b_valid || last_q);
    gnt_b      = !reset && b_valid && (!a_valid || !last_q);
    last_d     = gnt_a ? 1'b0 : gnt_b ? 1'b1 : last_q;
    ram_enable = gnt_a || gnt_b;
    ram_write  = gnt_b ? b_write : gnt_a && a_write;
    ram_addr   = gnt_b ? b_addr : a_addr;
    ram_idata  = gnt_b ? b_idata : a_idata;
    vld_d      = '0;
    own_d      = '0;
    vld_d[0]   = ram_enable && !ram_write;
    own_d[0]   = gnt_b;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b1;
      vld_q  <= '0;
      own_q  <= '0;
    end else begin
      last_q <= last_d;
      vld_q  <= vld_d;
      own_q  <= own_d;
    end
  end
  assign a_ready  = gnt_a;
  assign b_ready  = gnt_b;
  assign a_rvalid = vld_q[LATENCY-1] && !own_q[LATENCY-1];
  assign b_rvalid = vld_q[LATENCY-1] && own_q[LATENCY-1];
  assign a_rdata  = ram_odata;
  assign b_rdata  = ram_odata;
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of a single-clock true dual-port block RAM between two requesters, A and B.
- Grants at most one access per cycle, using round-robin priority.
- Drives the RAM port signals (enable, write, addr, idata).
- Routes each read result back to the requester that issued it, after a fixed, parameterised RAM read latency.
- Sits between client logic and one RAM port, either non-registered or output-registered.

Parameters:
DATA_WIDTH, 8, width of data words.
ADDR_WIDTH, 10, width of word addresses.
LATENCY, 1, RAM read latency in cycles; 1 = non-registered output, 2 = output-registered; legal range 1..4.

Ports:
clock  input  1  single clock for the block and the RAM port.
reset  input  1  synchronous, active-high reset.
a_valid  input  1  requester A has an access pending.
a_ready  output  1  A's access is accepted this cycle.
a_write  input  1  1 = write, 0 = read.
a_addr  input  ADDR_WIDTH  A's address.
a_idata  input  DATA_WIDTH  A's write data.
a_rvalid  output  1  A's read data is valid this cycle.
a_rdata  output  DATA_WIDTH  A's read data.
b_valid, b_ready, b_write, b_addr, b_idata, b_rvalid, b_rdata  same as the A ports, for requester B.
ram_enable  output  1  RAM port clock enable.
ram_write  output  1  RAM port write strobe.
ram_addr  output  ADDR_WIDTH  RAM port address.
ram_idata  output  DATA_WIDTH  RAM port write data.
ram_odata  input  DATA_WIDTH  RAM port read data.

Behaviour:
- Handshake: an access is accepted in a cycle where valid and ready are both 1.
  - ready is combinational from both valids and the priority register; requesters must not make valid depend on ready.
  - Once valid is asserted, the requester holds write, addr and idata stable until acceptance.
- Grant rule:
  - Only one valid: that requester is granted.
  - Both valid: the requester that did not win the most recent grant is granted.
  - Neither valid: no grant; ram_enable = 0.
- Priority register `last`:
  - 1 bit; reset value = B, so A wins the first tie.
  - Updated only on a cycle with a grant.
- RAM drive: combinational from the granted requester.
  - ram_enable = 1 on a grant cycle.
  - ram_write, ram_addr and ram_idata are muxed from the winner.
  - With no grant: ram_enable = 0, ram_write = 0; ram_addr and ram_idata are don't-care but must be driven (A's values).
- Writes: consume the grant cycle; no response is generated.
- Read return:
  - A tag pipeline of LATENCY stages, each holding {valid, owner}, shifts every cycle.
  - Stage 0 is loaded with {1, winner} on a read grant, and {0, x} otherwise.
  - The last stage drives the rvalid outputs: a_rvalid = valid & owner==A; b_rvalid = valid & owner==B.
  - A read accepted in cycle c produces rvalid exactly in cycle c+LATENCY.
  - a_rdata = b_rdata = ram_odata unconditionally; data is only meaningful while the matching rvalid is high.
- Throughput: one access per cycle; back-to-back reads from either or both requesters are fully pipelined, with no bubbles.
- Fairness: under continuous contention, grants alternate A, B, A, B...
  - A requester waits at most 1 cycle while the other is valid.
- Read-after-write to the same address from different requesters follows the RAM's same-port ordering, since only one port is used: the later-granted access observes the earlier one.
- Reset, including mid-operation:
  - While reset = 1: a_ready = b_ready = 0, ram_enable = 0, ram_write = 0.
  - All tag stages are cleared on the reset edge, so a_rvalid = b_rvalid = 0 from the cycle after reset is sampled.
  - In-flight reads are discarded, and `last` returns to B.
  - No output goes X after reset.

Test Plan:
- Reset, then A writes 8'h5A to addr 3 and B writes 8'hC3 to addr 4 in the same cycle:
  - A is granted first, B the next cycle.
  - Then A reads addr 4 -> a_rvalid high exactly LATENCY cycles after acceptance, a_rdata = 8'hC3; b_rvalid stays 0.
- Both requesters hold valid reads continuously for 8 cycles:
  - Grants alternate A, B, A, B.
  - rvalid pulses alternate with the same order and LATENCY offset, returning the correct data per address.
- A alone issues 4 back-to-back reads to addrs 0..3 (preloaded with 10, 11, 12, 13):
  - a_ready is high for 4 consecutive cycles.
  - a_rvalid is high for 4 consecutive cycles, with data 10, 11, 12, 13.
  - Run with LATENCY = 1 and LATENCY = 2.
- Issue a read from B, then assert reset one cycle after acceptance (for LATENCY = 2):
  - b_rvalid never asserts.
  - After reset, a simultaneous A/B request grants A first.
- Mixed traffic, A write then B read of the same address in consecutive grants:
  - B reads the newly written value.
  - ram_enable = 0 on every idle cycle, and ram_write never asserts on a read grant.
